ct_sysio_mc_top: RTL and testbench
==================================

Name: ct_sysio_mc_top

Overview:
- Parametrised multi-core system-IO block.
- Sits between the SoC pads and the CIU/CLINT/PLIC/PIU fabric, and serves CORE_NUM cores through index-aligned per-core buses.
- Registers pad-side inputs (system counter, APB base, debug requests/masks) and core-side status (low-power, JTAG power mode).
- Adds an L2-flush request/acknowledge state machine, a no-op indicator qualified by flush state, and system-counter monotonicity protection.

Parameters:
- CORE_NUM, 4, number of cores served; legal 1..8.
- APB_BASE_HI, 13, APB base upper bits kept; low (40-APB_BASE_HI) bits forced to 0.
- FLUSH_TO_W, 16, width of the flush watchdog counter.

Ports:
- forever_cpuclk  in  1  free-running CPU clock
- cpurst_b  in  1  asynchronous active-low reset
- axim_clk_en  in  1  AXI-side sample enable; all pad-side sampling is qualified by it
- pad_cpu_sys_cnt  in  64  system counter from pad
- pad_cpu_apb_base  in  40  APB base from pad
- pad_cpu_l2cache_flush_req  in  1  level flush request from pad
- l2c_sysio_flush_done  in  1  L2 flush complete pulse/level
- l2c_sysio_flush_idle  in  1  L2 idle
- ciu_xx_no_op  in  1  CIU idle
- pad_core_dbgrq_b  in  CORE_NUM  per-core debug request, active-low
- pad_core_dbg_mask  in  CORE_NUM  per-core debug mask
- piu_sysio_lpmd_b  in  2*CORE_NUM  per-core low-power mode, core i at [2i+1:2i]
- piu_sysio_jdb_pm  in  2*CORE_NUM  per-core JTAG power mode, same packing
- clint_ms_int, clint_mt_int, clint_ss_int, clint_st_int  in  CORE_NUM each  CLINT interrupts
- plic_me_int, plic_se_int  in  CORE_NUM each  PLIC interrupts
- sysio_piu_me_int, _se_int, _ms_int, _mt_int, _ss_int, _st_int  out  CORE_NUM each  registered interrupts to PIUs
- sysio_piu_dbgrq_b  out  CORE_NUM  registered debug request
- sysio_had_dbg_mask  out  CORE_NUM  registered debug mask
- core_pad_lpmd_b, core_pad_jdb_pm  out  2*CORE_NUM each  registered status to pad
- sysio_xx_time  out  64  sampled, monotonic system time
- sysio_xx_apb_base  out  40  {apb_base_hi, zeros}
- sysio_l2c_flush_req  out  1  flush request to L2
- cpu_pad_l2cache_flush_done  out  1  flush acknowledge to pad
- cpu_pad_flush_timeout  out  1  sticky watchdog flag
- cpu_pad_no_op  out  1  CPU quiescent

Behaviour:
- Clocking and reset: single clock forever_cpuclk; asynchronous active-low reset cpurst_b.
- Reset values:
  - all interrupt outputs 0; dbgrq_b all 1; dbg_mask 0.
  - lpmd_b all 2'b11; jdb_pm 2'b00.
  - time 0; apb_base 0.
  - flush_req 0, flush_done 0, timeout 0, no_op 0.
  - FSM in IDLE.
- Interrupts: plain 1-cycle register every clock, no axim_clk_en qualification.
- lpmd_b, jdb_pm, dbgrq_b, dbg_mask: 1-cycle register, updated only when axim_clk_en=1; otherwise hold.
- Time: when axim_clk_en=1 and pad_cpu_sys_cnt >= current time (unsigned 64-bit compare), load it; otherwise hold. Backward samples are discarded.
- APB base: when axim_clk_en=1, load pad_cpu_apb_base[39:40-APB_BASE_HI].
- Flush FSM (transitions evaluated only when axim_clk_en=1; otherwise state and outputs hold, watchdog frozen):
  - IDLE: req=1 -> REQ.
  - REQ: sysio_l2c_flush_req=1; watchdog counts up from 0.
    - done=1 -> ACK.
    - req=0 before done -> DRAIN; flush_req stays 1 until done, because an L2 flush is never aborted.
    - watchdog saturates at all-ones -> set sticky cpu_pad_flush_timeout and keep waiting.
  - ACK: flush_req=0, flush_done=1; req=0 -> IDLE, which clears done next cycle.
  - DRAIN: flush_req=1; done=1 -> IDLE, and no ack is given.
  - Timeout clears only on reset.
  - Simultaneous req=1 and done=1 in IDLE: done ignored; go to REQ.
- No-op: cpu_pad_no_op registered = ciu_xx_no_op & l2c_sysio_flush_idle & (state==IDLE), updated when axim_clk_en=1.
- Reset mid-flush: outputs return to reset values immediately (asynchronous); FSM to IDLE.

Optional Feature:
- Macro CT_SYSIO_SYS_CNT_GRAY_EN.
- Defined:
  - pad_cpu_sys_cnt is Gray-coded.
  - Two-stage binary conversion pipeline (register Gray, then convert and register).
  - Time update latency becomes 2 enabled samples instead of 1.
  - The monotonic compare applies to the converted binary value.
- Undefined: binary input, 1-sample latency.

Test Plan:
- Reset, then axim_clk_en=1 and sys_cnt=0x10 -> time=0x10 one cycle later. Then sys_cnt=0x0F -> time stays 0x10. Then sys_cnt=0x20 -> time=0x20.
- Flush: req=1 -> flush_req=1 next cycle. done=1 at cycle 5 -> flush_done=1 and flush_req=0. req=0 -> flush_done=0 one cycle later and state IDLE.
- Flush abort: req=1 for 2 cycles then 0 -> flush_req stays 1 until done=1, flush_done never asserts, then IDLE.
- Watchdog: FLUSH_TO_W=4, req=1, done never -> cpu_pad_flush_timeout=1 after 15 enabled cycles in REQ; remains set after a later done/ack.
- Enable gating: axim_clk_en=0 with dbgrq_b toggling and lpmd_b change -> outputs hold. Enabling -> update in 1 cycle. Interrupts plic_me_int=4'b1010 -> sysio_piu_me_int=4'b1010 next cycle regardless of enable.
- No-op: ciu_xx_no_op=1 and flush_idle=1 in IDLE -> no_op=1. Entering REQ -> no_op=0 next enabled cycle.

Source files
------------

// File: rtl/ct_sysio_mc_top.sv
// ct_sysio_mc_top: multi-core system-IO block between the SoC pads and the
// CIU/CLINT/PLIC/PIU fabric. Registers pad-side inputs (system counter, APB
// base, debug requests/masks) under axim_clk_en, registers per-core status
// toward the pads, runs the L2-flush request/acknowledge handshake with a
// sticky watchdog, and reports a flush-qualified no-op indicator.
// Optional build macro: CT_SYSIO_SYS_CNT_GRAY_EN -- pad_cpu_sys_cnt is
// Gray-coded and converted through a 2-stage pipeline (2-sample latency).
module ct_sysio_mc_top #(
    parameter int CORE_NUM    = 4,
    parameter int APB_BASE_HI = 13,
    parameter int FLUSH_TO_W  = 16
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    axim_clk_en,
    input  logic [63:0]             pad_cpu_sys_cnt,
    input  logic [39:0]             pad_cpu_apb_base,
    input  logic                    pad_cpu_l2cache_flush_req,
    input  logic                    l2c_sysio_flush_done,
    input  logic                    l2c_sysio_flush_idle,
    input  logic                    ciu_xx_no_op,
    input  logic [CORE_NUM-1:0]     pad_core_dbgrq_b,
    input  logic [CORE_NUM-1:0]     pad_core_dbg_mask,
    input  logic [2*CORE_NUM-1:0]   piu_sysio_lpmd_b,
    input  logic [2*CORE_NUM-1:0]   piu_sysio_jdb_pm,
    input  logic [CORE_NUM-1:0]     clint_ms_int,
    input  logic [CORE_NUM-1:0]     clint_mt_int,
    input  logic [CORE_NUM-1:0]     clint_ss_int,
    input  logic [CORE_NUM-1:0]     clint_st_int,
    input  logic [CORE_NUM-1:0]     plic_me_int,
    input  logic [CORE_NUM-1:0]     plic_se_int,
    output logic [CORE_NUM-1:0]     sysio_piu_me_int,
    output logic [CORE_NUM-1:0]     sysio_piu_se_int,
    output logic [CORE_NUM-1:0]     sysio_piu_ms_int,
    output logic [CORE_NUM-1:0]     sysio_piu_mt_int,
    output logic [CORE_NUM-1:0]     sysio_piu_ss_int,
    output logic [CORE_NUM-1:0]     sysio_piu_st_int,
    output logic [CORE_NUM-1:0]     sysio_piu_dbgrq_b,
    output logic [CORE_NUM-1:0]     sysio_had_dbg_mask,
    output logic [2*CORE_NUM-1:0]   core_pad_lpmd_b,
    output logic [2*CORE_NUM-1:0]   core_pad_jdb_pm,
    output logic [63:0]             sysio_xx_time,
    output logic [39:0]             sysio_xx_apb_base,
    output logic                    sysio_l2c_flush_req,
    output logic                    cpu_pad_l2cache_flush_done,
    output logic                    cpu_pad_flush_timeout,
    output logic                    cpu_pad_no_op
);

    localparam int APB_LO_W = 40 - APB_BASE_HI;
    localparam logic [FLUSH_TO_W-1:0] WD_MAX = {FLUSH_TO_W{1'b1}};
    localparam logic [FLUSH_TO_W-1:0] WD_ONE = {{(FLUSH_TO_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } flush_state_t;

    flush_state_t              flush_state;
    flush_state_t              flush_state_nxt;
    logic [FLUSH_TO_W-1:0]     flush_wd_cnt;
    logic [APB_BASE_HI-1:0]    apb_base_hi_q;
    logic [63:0]               sys_cnt_smp;

    // Interrupts are retimed every cycle; they do not depend on the AXI enable.
    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sysio_piu_me_int <= '0;
            sysio_piu_se_int <= '0;
            sysio_piu_ms_int <= '0;
            sysio_piu_mt_int <= '0;
            sysio_piu_ss_int <= '0;
            sysio_piu_st_int <= '0;
        end else begin
            sysio_piu_me_int <= plic_me_int;
            sysio_piu_se_int <= plic_se_int;
            sysio_piu_ms_int <= clint_ms_int;
            sysio_piu_mt_int <= clint_mt_int;
            sysio_piu_ss_int <= clint_ss_int;
            sysio_piu_st_int <= clint_st_int;
        end
    end

    // Debug and power-mode status, sampled only on AXI-enabled cycles.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sysio_piu_dbgrq_b  <= '1;
            sysio_had_dbg_mask <= '0;
            core_pad_lpmd_b    <= '1;
            core_pad_jdb_pm    <= '0;
            apb_base_hi_q      <= '0;
        end else if (axim_clk_en) begin
            sysio_piu_dbgrq_b  <= pad_core_dbgrq_b;
            sysio_had_dbg_mask <= pad_core_dbg_mask;
            core_pad_lpmd_b    <= piu_sysio_lpmd_b;
            core_pad_jdb_pm    <= piu_sysio_jdb_pm;
            apb_base_hi_q      <= pad_cpu_apb_base[39:APB_LO_W];
        end
    end

    assign sysio_xx_apb_base = {apb_base_hi_q, {APB_LO_W{1'b0}}};

`ifdef CT_SYSIO_SYS_CNT_GRAY_EN
    logic [63:0] sys_cnt_gray_q;

    function automatic logic [63:0] gray_to_bin(input logic [63:0] gray);
        logic [63:0] bin;
        bin[63] = gray[63];
        for (int i = 62; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // First pipeline stage: capture the raw Gray count before conversion.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sys_cnt_gray_q <= '0;
        end else if (axim_clk_en) begin
            sys_cnt_gray_q <= pad_cpu_sys_cnt;
        end
    end

    assign sys_cnt_smp = gray_to_bin(sys_cnt_gray_q);
`else
    assign sys_cnt_smp = pad_cpu_sys_cnt;
`endif

    // System time only moves forward; a backward sample is dropped.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sysio_xx_time <= '0;
        end else if (axim_clk_en && (sys_cnt_smp >= sysio_xx_time)) begin
            sysio_xx_time <= sys_cnt_smp;
        end
    end

    // Flush FSM state register.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            flush_state <= ST_IDLE;
        end else begin
            flush_state <= flush_state_nxt;
        end
    end

    // Flush FSM next state and Moore outputs; an issued flush is never aborted.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        flush_state_nxt            = flush_state;
        sysio_l2c_flush_req        = 1'b0;
        cpu_pad_l2cache_flush_done = 1'b0;
        case (flush_state)
            ST_IDLE: begin
                if (axim_clk_en && pad_cpu_l2cache_flush_req) begin
                    flush_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                sysio_l2c_flush_req = 1'b1;
                if (axim_clk_en) begin
                    if (l2c_sysio_flush_done) begin
                        flush_state_nxt = ST_ACK;
                    end else if (!pad_cpu_l2cache_flush_req) begin
                        flush_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_ACK: begin
                cpu_pad_l2cache_flush_done = 1'b1;
                if (axim_clk_en && !pad_cpu_l2cache_flush_req) begin
                    flush_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                sysio_l2c_flush_req = 1'b1;
                if (axim_clk_en && l2c_sysio_flush_done) begin
                    flush_state_nxt = ST_IDLE;
                end
            end
            default: flush_state_nxt = ST_IDLE;
        endcase
    end

    // Watchdog counts enabled cycles in REQ; saturation sets a sticky timeout.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            flush_wd_cnt          <= '0;
            cpu_pad_flush_timeout <= 1'b0;
        end else if (axim_clk_en) begin
            if (flush_state == ST_REQ) begin
                if (flush_wd_cnt != WD_MAX) begin
                    flush_wd_cnt <= flush_wd_cnt + WD_ONE;
                end
                if (flush_wd_cnt == WD_MAX - WD_ONE) begin
                    cpu_pad_flush_timeout <= 1'b1;
                end
            end else if (flush_state == ST_IDLE) begin
                flush_wd_cnt <= '0;
            end
        end
    end

    // CPU is quiescent only when CIU and L2 are idle and no flush is in flight.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cpu_pad_no_op <= 1'b0;
        end else if (axim_clk_en) begin
            cpu_pad_no_op <= ciu_xx_no_op & l2c_sysio_flush_idle &
                             (flush_state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ct_sysio_mc_top.sv
// tb_ct_sysio_mc_top: self-checking bench for ct_sysio_mc_top with a small
// transaction-level reference model (flush handshake tracked as busy/ack/abort
// flags, time as a running maximum).
module tb_ct_sysio_mc_top;

    localparam int N      = 4;
    localparam int APB_HI = 13;
    localparam int TO_W   = 4;
    localparam int WD_MAX = (1 << TO_W) - 1;
    localparam logic [39:0] APB_MASK = ~((40'd1 << (40 - APB_HI)) - 40'd1);
`ifdef CT_SYSIO_SYS_CNT_GRAY_EN
    localparam int TIME_LAT = 2;
`else
    localparam int TIME_LAT = 1;
`endif

    logic            forever_cpuclk = 1'b0;
    logic            cpurst_b;
    logic            axim_clk_en;
    logic [63:0]     pad_cpu_sys_cnt;
    logic [39:0]     pad_cpu_apb_base;
    logic            pad_cpu_l2cache_flush_req;
    logic            l2c_sysio_flush_done;
    logic            l2c_sysio_flush_idle;
    logic            ciu_xx_no_op;
    logic [N-1:0]    pad_core_dbgrq_b, pad_core_dbg_mask;
    logic [2*N-1:0]  piu_sysio_lpmd_b, piu_sysio_jdb_pm;
    logic [N-1:0]    clint_ms_int, clint_mt_int, clint_ss_int, clint_st_int;
    logic [N-1:0]    plic_me_int, plic_se_int;
    logic [N-1:0]    sysio_piu_me_int, sysio_piu_se_int, sysio_piu_ms_int;
    logic [N-1:0]    sysio_piu_mt_int, sysio_piu_ss_int, sysio_piu_st_int;
    logic [N-1:0]    sysio_piu_dbgrq_b, sysio_had_dbg_mask;
    logic [2*N-1:0]  core_pad_lpmd_b, core_pad_jdb_pm;
    logic [63:0]     sysio_xx_time;
    logic [39:0]     sysio_xx_apb_base;
    logic            sysio_l2c_flush_req, cpu_pad_l2cache_flush_done;
    logic            cpu_pad_flush_timeout, cpu_pad_no_op;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [6*N-1:0]  m_irq;
    logic [N-1:0]    m_dbgrq, m_mask;
    logic [2*N-1:0]  m_lpmd, m_jdb;
    logic [63:0]     m_time, m_gray;
    logic [39:0]     m_apb;
    logic            m_noop, m_busy, m_ack, m_abort, m_to;
    int              m_wd;

    ct_sysio_mc_top #(.CORE_NUM(N), .APB_BASE_HI(APB_HI), .FLUSH_TO_W(TO_W)) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b), .axim_clk_en(axim_clk_en),
        .pad_cpu_sys_cnt(pad_cpu_sys_cnt), .pad_cpu_apb_base(pad_cpu_apb_base),
        .pad_cpu_l2cache_flush_req(pad_cpu_l2cache_flush_req),
        .l2c_sysio_flush_done(l2c_sysio_flush_done), .l2c_sysio_flush_idle(l2c_sysio_flush_idle),
        .ciu_xx_no_op(ciu_xx_no_op), .pad_core_dbgrq_b(pad_core_dbgrq_b),
        .pad_core_dbg_mask(pad_core_dbg_mask), .piu_sysio_lpmd_b(piu_sysio_lpmd_b),
        .piu_sysio_jdb_pm(piu_sysio_jdb_pm), .clint_ms_int(clint_ms_int),
        .clint_mt_int(clint_mt_int), .clint_ss_int(clint_ss_int), .clint_st_int(clint_st_int),
        .plic_me_int(plic_me_int), .plic_se_int(plic_se_int),
        .sysio_piu_me_int(sysio_piu_me_int), .sysio_piu_se_int(sysio_piu_se_int),
        .sysio_piu_ms_int(sysio_piu_ms_int), .sysio_piu_mt_int(sysio_piu_mt_int),
        .sysio_piu_ss_int(sysio_piu_ss_int), .sysio_piu_st_int(sysio_piu_st_int),
        .sysio_piu_dbgrq_b(sysio_piu_dbgrq_b), .sysio_had_dbg_mask(sysio_had_dbg_mask),
        .core_pad_lpmd_b(core_pad_lpmd_b), .core_pad_jdb_pm(core_pad_jdb_pm),
        .sysio_xx_time(sysio_xx_time), .sysio_xx_apb_base(sysio_xx_apb_base),
        .sysio_l2c_flush_req(sysio_l2c_flush_req),
        .cpu_pad_l2cache_flush_done(cpu_pad_l2cache_flush_done),
        .cpu_pad_flush_timeout(cpu_pad_flush_timeout), .cpu_pad_no_op(cpu_pad_no_op)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached at %0t", $time);
        $fatal(1);
    end

    // Encode a binary count as the pad would present it.
    function automatic logic [63:0] enc(input logic [63:0] v);
`ifdef CT_SYSIO_SYS_CNT_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // Gray decode by prefix-XOR doubling.
    function automatic logic [63:0] gray_dec(input logic [63:0] g);
        logic [63:0] b;
        b = g;
        for (int s = 1; s < 64; s = s * 2) b = b ^ (b >> s);
        return b;
    endfunction

    task automatic model_reset();
        m_irq = '0; m_dbgrq = '1; m_mask = '0; m_lpmd = '1; m_jdb = '0;
        m_time = '0; m_gray = '0; m_apb = '0; m_noop = 1'b0;
        m_busy = 1'b0; m_ack = 1'b0; m_abort = 1'b0; m_to = 1'b0; m_wd = 0;
    endtask

    // Advance one clock: compute the model's next state from the inputs that
    // the edge will sample, then let the edge happen and settle.
    task automatic step();
        logic [6*N-1:0] n_irq;
        logic [N-1:0]   n_dbgrq, n_mask;
        logic [2*N-1:0] n_lpmd, n_jdb;
        logic [63:0]    n_time, n_gray, smp;
        logic [39:0]    n_apb;
        logic           n_noop, b, a, ab, t, idle;
        int             w;
        n_irq = {plic_me_int, plic_se_int, clint_ms_int, clint_mt_int, clint_ss_int, clint_st_int};
        n_dbgrq = m_dbgrq; n_mask = m_mask; n_lpmd = m_lpmd; n_jdb = m_jdb;
        n_time = m_time; n_gray = m_gray; n_apb = m_apb; n_noop = m_noop;
        b = m_busy; a = m_ack; ab = m_abort; t = m_to; w = m_wd;
        idle = !m_busy && !m_ack;
        if (axim_clk_en) begin
            n_dbgrq = pad_core_dbgrq_b; n_mask = pad_core_dbg_mask;
            n_lpmd = piu_sysio_lpmd_b; n_jdb = piu_sysio_jdb_pm;
            n_apb = pad_cpu_apb_base & APB_MASK;
`ifdef CT_SYSIO_SYS_CNT_GRAY_EN
            smp = gray_dec(m_gray);
            n_gray = pad_cpu_sys_cnt;
`else
            smp = pad_cpu_sys_cnt;
`endif
            if (smp >= m_time) n_time = smp;
            n_noop = ciu_xx_no_op & l2c_sysio_flush_idle & idle;
            if (idle) begin
                if (pad_cpu_l2cache_flush_req) begin b = 1'b1; ab = 1'b0; w = 0; end
            end else if (m_busy && !m_abort) begin
                if (w < WD_MAX) w = w + 1;
                if (w == WD_MAX) t = 1'b1;
                if (l2c_sysio_flush_done) begin b = 1'b0; a = 1'b1; end
                else if (!pad_cpu_l2cache_flush_req) ab = 1'b1;
            end else if (m_busy) begin
                if (l2c_sysio_flush_done) begin b = 1'b0; ab = 1'b0; end
            end else if (!pad_cpu_l2cache_flush_req) begin
                a = 1'b0;
            end
        end
        @(posedge forever_cpuclk);
        #1;
        m_irq = n_irq; m_dbgrq = n_dbgrq; m_mask = n_mask; m_lpmd = n_lpmd; m_jdb = n_jdb;
        m_time = n_time; m_gray = n_gray; m_apb = n_apb; m_noop = n_noop;
        m_busy = b; m_ack = a; m_abort = ab; m_to = t; m_wd = w;
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0; axim_clk_en = 1'b1;
        pad_cpu_sys_cnt = '0; pad_cpu_apb_base = 40'hFF_FFFF_FFFF;
        pad_cpu_l2cache_flush_req = 1'b0; l2c_sysio_flush_done = 1'b0;
        l2c_sysio_flush_idle = 1'b1; ciu_xx_no_op = 1'b1;
        pad_core_dbgrq_b = '0; pad_core_dbg_mask = '1;
        piu_sysio_lpmd_b = '0; piu_sysio_jdb_pm = '1;
        clint_ms_int = '1; clint_mt_int = '1; clint_ss_int = '1; clint_st_int = '1;
        plic_me_int = '1; plic_se_int = '1;
        model_reset();
        #23;
        n_cmp++; if ({sysio_piu_me_int, sysio_piu_se_int, sysio_piu_ms_int, sysio_piu_mt_int,
                      sysio_piu_ss_int, sysio_piu_st_int} !== '0) begin
            n_bad++; $display("FAIL reset_irq got=%h exp=0", {sysio_piu_me_int, sysio_piu_st_int}); end
        n_cmp++; if ({sysio_piu_dbgrq_b, sysio_had_dbg_mask} !== 8'hF0) begin
            n_bad++; $display("FAIL reset_dbg got=%h exp=f0", {sysio_piu_dbgrq_b, sysio_had_dbg_mask}); end
        n_cmp++; if ({core_pad_lpmd_b, core_pad_jdb_pm} !== 16'hFF00) begin
            n_bad++; $display("FAIL reset_pm got=%h exp=ff00", {core_pad_lpmd_b, core_pad_jdb_pm}); end
        n_cmp++; if (sysio_xx_time !== 64'd0 || sysio_xx_apb_base !== 40'd0) begin
            n_bad++; $display("FAIL reset_time_apb got=%h/%h exp=0/0", sysio_xx_time, sysio_xx_apb_base); end
        n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done, cpu_pad_flush_timeout,
                      cpu_pad_no_op} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flush got=%b exp=0000", {sysio_l2c_flush_req,
                cpu_pad_l2cache_flush_done, cpu_pad_flush_timeout, cpu_pad_no_op}); end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        step();
    endtask

    task automatic test_time();
        logic [63:0] vals [3];
        logic [63:0] exps [3];
        vals[0] = 64'h10; vals[1] = 64'h0F; vals[2] = 64'h20;
        exps[0] = 64'h10; exps[1] = 64'h10; exps[2] = 64'h20;
        axim_clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pad_cpu_sys_cnt = enc(vals[i]);
            repeat (TIME_LAT) step();
            n_cmp++; if (sysio_xx_time !== exps[i] || m_time !== exps[i]) begin
                n_bad++; $display("FAIL time_dir%0d got=%h exp=%h", i, sysio_xx_time, exps[i]); end
        end
        for (int i = 0; i < 40; i++) begin
            logic [63:0] v;
            axim_clk_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) v = m_time - 64'($urandom_range(1, 1000));
            else v = m_time + {32'($urandom_range(0, 255)), $urandom};
            pad_cpu_sys_cnt = enc(v);
            step();
            n_cmp++; if (sysio_xx_time !== m_time) begin
                n_bad++; $display("FAIL time_rnd%0d got=%h exp=%h", i, sysio_xx_time, m_time); end
        end
        axim_clk_en = 1'b1;
    endtask

    task automatic test_flush();
        axim_clk_en = 1'b1; l2c_sysio_flush_done = 1'b0;
        pad_cpu_l2cache_flush_req = 1'b1;
        step();
        n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done} !== 2'b10) begin
            n_bad++; $display("FAIL flush_req got=%b exp=10", {sysio_l2c_flush_req, cpu_pad_l2cache_flush_done}); end
        repeat (3) step();
        l2c_sysio_flush_done = 1'b1;
        step();
        n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done} !== 2'b01) begin
            n_bad++; $display("FAIL flush_ack got=%b exp=01", {sysio_l2c_flush_req, cpu_pad_l2cache_flush_done}); end
        l2c_sysio_flush_done = 1'b0;
        step();
        n_cmp++; if (cpu_pad_l2cache_flush_done !== 1'b1) begin
            n_bad++; $display("FAIL flush_ack_hold got=%b exp=1", cpu_pad_l2cache_flush_done); end
        pad_cpu_l2cache_flush_req = 1'b0;
        step();
        n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done} !== 2'b00 || m_busy || m_ack) begin
            n_bad++; $display("FAIL flush_idle got=%b exp=00", {sysio_l2c_flush_req, cpu_pad_l2cache_flush_done}); end
    endtask

    task automatic test_abort();
        pad_cpu_l2cache_flush_req = 1'b1;
        repeat (2) step();
        pad_cpu_l2cache_flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done} !== 2'b10) begin
                n_bad++; $display("FAIL abort_drain%0d got=%b exp=10", i,
                    {sysio_l2c_flush_req, cpu_pad_l2cache_flush_done}); end
        end
        l2c_sysio_flush_done = 1'b1;
        step();
        l2c_sysio_flush_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done} !== 2'b00) begin
                n_bad++; $display("FAIL abort_end%0d got=%b exp=00", i,
                    {sysio_l2c_flush_req, cpu_pad_l2cache_flush_done}); end
            step();
        end
    endtask

    task automatic test_enable();
        logic [39:0] apb;
        axim_clk_en = 1'b1;
        pad_core_dbgrq_b = 4'hF; pad_core_dbg_mask = 4'h0;
        piu_sysio_lpmd_b = 8'hFF; piu_sysio_jdb_pm = 8'h00;
        step();
        apb = {8'($urandom), $urandom};
        axim_clk_en = 1'b0;
        pad_core_dbgrq_b = 4'b0101; pad_core_dbg_mask = 4'b0011;
        piu_sysio_lpmd_b = 8'h5A; piu_sysio_jdb_pm = 8'hA5;
        pad_cpu_apb_base = apb; plic_me_int = 4'b1010;
        step();
        n_cmp++; if (sysio_piu_me_int !== 4'b1010) begin
            n_bad++; $display("FAIL en_irq got=%b exp=1010", sysio_piu_me_int); end
        pad_core_dbgrq_b = 4'b1010;
        step();
        n_cmp++; if ({sysio_piu_dbgrq_b, sysio_had_dbg_mask, core_pad_lpmd_b, core_pad_jdb_pm} !== 24'hF0FF00
                     || sysio_xx_apb_base !== m_apb) begin
            n_bad++; $display("FAIL en_hold got=%h exp=f0ff00", {sysio_piu_dbgrq_b, sysio_had_dbg_mask,
                core_pad_lpmd_b, core_pad_jdb_pm}); end
        axim_clk_en = 1'b1;
        step();
        n_cmp++; if ({sysio_piu_dbgrq_b, sysio_had_dbg_mask, core_pad_lpmd_b, core_pad_jdb_pm} !== 24'hA35AA5) begin
            n_bad++; $display("FAIL en_update got=%h exp=a35aa5", {sysio_piu_dbgrq_b, sysio_had_dbg_mask,
                core_pad_lpmd_b, core_pad_jdb_pm}); end
        n_cmp++; if (sysio_xx_apb_base !== {apb[39:27], 27'd0}) begin
            n_bad++; $display("FAIL en_apb got=%h exp=%h", sysio_xx_apb_base, {apb[39:27], 27'd0}); end
    endtask

    task automatic test_noop();
        axim_clk_en = 1'b1; ciu_xx_no_op = 1'b1; l2c_sysio_flush_idle = 1'b1;
        pad_cpu_l2cache_flush_req = 1'b0; l2c_sysio_flush_done = 1'b0;
        step();
        n_cmp++; if (cpu_pad_no_op !== 1'b1) begin
            n_bad++; $display("FAIL noop_idle got=%b exp=1", cpu_pad_no_op); end
        pad_cpu_l2cache_flush_req = 1'b1;
        step();
        step();
        n_cmp++; if (cpu_pad_no_op !== 1'b0) begin
            n_bad++; $display("FAIL noop_req got=%b exp=0", cpu_pad_no_op); end
        l2c_sysio_flush_done = 1'b1;
        step();
        pad_cpu_l2cache_flush_req = 1'b0; l2c_sysio_flush_done = 1'b0;
        step();
        ciu_xx_no_op = 1'b0;
        step();
        n_cmp++; if (cpu_pad_no_op !== 1'b0 || m_noop !== 1'b0) begin
            n_bad++; $display("FAIL noop_ciu_busy got=%b exp=0", cpu_pad_no_op); end
        ciu_xx_no_op = 1'b1;
    endtask

    task automatic test_watchdog();
        axim_clk_en = 1'b1; l2c_sysio_flush_done = 1'b0;
        pad_cpu_l2cache_flush_req = 1'b1;
        step();
        for (int i = 1; i <= 14; i++) begin
            if (i == 7) begin
                axim_clk_en = 1'b0;
                repeat (3) step();
                axim_clk_en = 1'b1;
            end
            step();
        end
        n_cmp++; if (cpu_pad_flush_timeout !== 1'b0) begin
            n_bad++; $display("FAIL wd_early got=%b exp=0", cpu_pad_flush_timeout); end
        step();
        n_cmp++; if (cpu_pad_flush_timeout !== 1'b1) begin
            n_bad++; $display("FAIL wd_fire got=%b exp=1", cpu_pad_flush_timeout); end
        step();
        n_cmp++; if (sysio_l2c_flush_req !== 1'b1) begin
            n_bad++; $display("FAIL wd_still_req got=%b exp=1", sysio_l2c_flush_req); end
        l2c_sysio_flush_done = 1'b1;
        step();
        l2c_sysio_flush_done = 1'b0; pad_cpu_l2cache_flush_req = 1'b0;
        step();
        n_cmp++; if ({cpu_pad_flush_timeout, sysio_l2c_flush_req, cpu_pad_l2cache_flush_done} !== 3'b100) begin
            n_bad++; $display("FAIL wd_sticky got=%b exp=100", {cpu_pad_flush_timeout,
                sysio_l2c_flush_req, cpu_pad_l2cache_flush_done}); end
    endtask

    task automatic test_reset_mid_flush();
        pad_cpu_l2cache_flush_req = 1'b1; axim_clk_en = 1'b1;
        step();
        step();
        cpurst_b = 1'b0;
        #1;
        model_reset();
        n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done, cpu_pad_flush_timeout,
                      cpu_pad_no_op} !== 4'b0000 || sysio_xx_time !== 64'd0) begin
            n_bad++; $display("FAIL rst_mid got=%b/%h exp=0000/0", {sysio_l2c_flush_req,
                cpu_pad_l2cache_flush_done, cpu_pad_flush_timeout, cpu_pad_no_op}, sysio_xx_time); end
        n_cmp++; if ({sysio_piu_dbgrq_b, core_pad_lpmd_b, core_pad_jdb_pm} !== 20'hFFF00) begin
            n_bad++; $display("FAIL rst_mid_status got=%h exp=fff00", {sysio_piu_dbgrq_b,
                core_pad_lpmd_b, core_pad_jdb_pm}); end
        pad_cpu_l2cache_flush_req = 1'b0;
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [63:0] v;
            axim_clk_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) pad_cpu_l2cache_flush_req = ~pad_cpu_l2cache_flush_req;
            l2c_sysio_flush_done = ($urandom_range(0, 4) == 0);
            l2c_sysio_flush_idle = 1'($urandom); ciu_xx_no_op = 1'($urandom);
            {plic_me_int, plic_se_int, clint_ms_int} = 12'($urandom);
            {clint_mt_int, clint_ss_int, clint_st_int} = 12'($urandom);
            {pad_core_dbgrq_b, pad_core_dbg_mask} = 8'($urandom);
            {piu_sysio_lpmd_b, piu_sysio_jdb_pm} = 16'($urandom);
            pad_cpu_apb_base = {8'($urandom), $urandom};
            if ($urandom_range(0, 2) == 0) v = m_time - 64'($urandom_range(1, 50));
            else v = m_time + 64'($urandom_range(0, 5000));
            pad_cpu_sys_cnt = enc(v);
            step();
            n_cmp++; if ({sysio_piu_me_int, sysio_piu_se_int, sysio_piu_ms_int, sysio_piu_mt_int,
                          sysio_piu_ss_int, sysio_piu_st_int} !== m_irq) begin
                n_bad++; $display("FAIL rnd_irq%0d got=%h exp=%h", i, {sysio_piu_me_int, sysio_piu_se_int,
                    sysio_piu_ms_int, sysio_piu_mt_int, sysio_piu_ss_int, sysio_piu_st_int}, m_irq); end
            n_cmp++; if ({sysio_piu_dbgrq_b, sysio_had_dbg_mask, core_pad_lpmd_b, core_pad_jdb_pm}
                         !== {m_dbgrq, m_mask, m_lpmd, m_jdb}) begin
                n_bad++; $display("FAIL rnd_status%0d got=%h exp=%h", i, {sysio_piu_dbgrq_b,
                    sysio_had_dbg_mask, core_pad_lpmd_b, core_pad_jdb_pm}, {m_dbgrq, m_mask, m_lpmd, m_jdb}); end
            n_cmp++; if (sysio_xx_time !== m_time || sysio_xx_apb_base !== m_apb) begin
                n_bad++; $display("FAIL rnd_time_apb%0d got=%h/%h exp=%h/%h", i, sysio_xx_time,
                    sysio_xx_apb_base, m_time, m_apb); end
            n_cmp++; if ({sysio_l2c_flush_req, cpu_pad_l2cache_flush_done, cpu_pad_flush_timeout,
                          cpu_pad_no_op} !== {m_busy, m_ack, m_to, m_noop}) begin
                n_bad++; $display("FAIL rnd_flush%0d got=%b exp=%b", i, {sysio_l2c_flush_req,
                    cpu_pad_l2cache_flush_done, cpu_pad_flush_timeout, cpu_pad_no_op},
                    {m_busy, m_ack, m_to, m_noop}); end
        end
    endtask

    initial begin
        test_reset();
        test_time();
        test_flush();
        test_abort();
        test_enable();
        test_noop();
        test_watchdog();
        test_reset_mid_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
